// File: rtl/mem_block_fetcher.sv
// mem_block_fetcher: sequences runs of block reads from the coprocessor memory
// through its one-cycle registered read port. Each block goes to the compute
// stage over a valid/ready handshake. A completion word goes to the status
// cell at the end of every job.
// Optional macro FETCH_CYCLE_COUNT_EN: reports a saturating count of the
// active fetch cycles in status bits [31:16].
module mem_block_fetcher #(
  parameter int LOG_SIZE   = 10,
  parameter int CELL_WIDTH = 32,
  parameter int BLOCKS     = 4,
  localparam int WIDTH     = BLOCKS * CELL_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_start,
  input  logic [LOG_SIZE-1:0]   in_base_addr,
  input  logic [7:0]            in_count,
  output logic [LOG_SIZE-1:0]   out_mem_address,
  output logic                  out_mem_read_en,
  input  logic [WIDTH-1:0]      in_mem_data,
  output logic [CELL_WIDTH-1:0] out_status,
  output logic                  out_status_we,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic                  out_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  // Address arithmetic carries one extra bit, so a run that walks off the
  // top of memory shows up as a range error rather than wrapping to cell 0.
  localparam logic [LOG_SIZE:0] ADDR_STEP = (LOG_SIZE+1)'(BLOCKS);
  localparam logic [LOG_SIZE:0] ADDR_SPAN = (LOG_SIZE+1)'(BLOCKS - 1);
  localparam logic [LOG_SIZE:0] ADDR_MAX  = {1'b0, {LOG_SIZE{1'b1}}};

  state_t                state_q, state_d;
  logic [LOG_SIZE:0]     cur_addr_q, cur_addr_d;
  logic [7:0]            remaining_q, remaining_d;
  logic [7:0]            delivered_q, delivered_d;
  logic                  error_q, error_d;
  logic [LOG_SIZE-1:0]   addr_hold_q, addr_hold_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [LOG_SIZE:0]     end_addr;
  logic                  range_err;
  logic [15:0]           cyc_field;
  logic [CELL_WIDTH-1:0] status_word;

  assign end_addr  = cur_addr_q + ADDR_SPAN;
  assign range_err = end_addr > ADDR_MAX;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  // Count cycles spent actively fetching, restarting on each accepted job.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == S_IDLE && in_start) begin
      cyc_cnt_d = '0;
    end else if ((state_q == S_REQ || state_q == S_WAIT || state_q == S_HOLD)
                 && cyc_cnt_q != 16'hFFFF) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) cyc_cnt_q <= '0;
    else          cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_field = cyc_cnt_q;
`else
  assign cyc_field = '0;
`endif

  // Assemble the completion word: done, error, delivered count, cycle field.
  always_comb begin
    status_word        = '0;
    status_word[0]     = 1'b1;
    status_word[1]     = error_q;
    status_word[15:8]  = delivered_q;
    status_word[31:16] = cyc_field;
  end

  // Next-state and output logic for the fetch sequencer.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    delivered_d     = delivered_q;
    error_d         = error_q;
    addr_hold_d     = addr_hold_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    out_mem_address = addr_hold_q;
    out_mem_read_en = 1'b0;
    out_status      = '0;
    out_status_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          cur_addr_d  = {1'b0, in_base_addr};
          remaining_d = in_count;
          delivered_d = '0;
          error_d     = 1'b0;
          state_d     = (in_count == 8'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        out_mem_address = cur_addr_q[LOG_SIZE-1:0];
        addr_hold_d     = cur_addr_q[LOG_SIZE-1:0];
        if (range_err) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          out_mem_read_en = 1'b1;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        out_data_d  = in_mem_data;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (in_ready) begin
          out_valid_d = 1'b0;
          delivered_d = delivered_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          cur_addr_d  = cur_addr_q + ADDR_STEP;
          state_d     = (remaining_q == 8'd1) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        out_status    = status_word;
        out_status_we = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      delivered_q <= '0;
      error_q     <= 1'b0;
      addr_hold_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      delivered_q <= delivered_d;
      error_q     <= error_d;
      addr_hold_q <= addr_hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_busy  = (state_q != S_IDLE);

endmodule

// File: doc/mem_block_fetcher.md
Name: mem_block_fetcher

Overview:
Read sequencer directly downstream of the coprocessor memory. On a start pulse it fetches a run of consecutive blocks (BLOCKS cells of CELL_WIDTH each) from memory through the memory's registered read port. It streams each block to the compute stage over a valid/ready handshake. On completion it writes a completion word into the memory status cell.

Parameters:
LOG_SIZE, 10, memory address width in cells
CELL_WIDTH, 32, bits per memory cell
BLOCKS, 4, cells per memory read
WIDTH, BLOCKS*CELL_WIDTH, block width; derived, not overridden

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous, active-high reset
in_start  input  1  one-cycle job request
in_base_addr  input  LOG_SIZE  cell address of first block
in_count  input  8  number of blocks to fetch (0 allowed)
out_mem_address  output  LOG_SIZE  to memory in_address
out_mem_read_en  output  1  to memory in_read_en
in_mem_data  input  WIDTH  from memory out_data (1-cycle latency)
out_status  output  CELL_WIDTH  to memory in_status
out_status_we  output  1  to memory in_write_status_en
out_data  output  WIDTH  block to compute stage
out_valid  output  1  out_data valid
in_ready  input  1  compute stage accepts out_data
out_busy  output  1  job in progress

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; internal address/remaining/delivered counters 0.
- States: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE: busy=0. in_start=1 latches base→cur_addr, count→remaining, clears delivered. If count==0 go to DONE, else go to REQ.
- REQ: busy=1, read_en=1, mem_address=cur_addr. Range check uses LOG_SIZE+1-bit arithmetic. If cur_addr+BLOCKS-1 > 2^LOG_SIZE-1: read_en stays 0, error flag set, go to DONE. Otherwise go to WAIT.
- WAIT: read_en=0. At the end of the cycle, in_mem_data is captured into out_data and out_valid is set. Go to HOLD.
- HOLD: out_valid=1 and out_data is held stable until in_ready=1. On the handshake:
  - out_valid clears, delivered+1, remaining-1, cur_addr+BLOCKS (LOG_SIZE+1-bit).
  - If remaining was 1, go to DONE; else go to REQ.
  - A carry out of cur_addr is caught by the next REQ range check.
- DONE: exactly one cycle. status_we=1 and out_status is:
  - bit0 = 1 (done)
  - bit1 = error
  - bits[15:8] = delivered
  - bits[31:16] per optional feature
  - other bits 0
  Then go to IDLE.
- out_status is 0 whenever status_we=0. out_mem_address holds its last value outside REQ.
- Throughput: one block per 3 cycles with in_ready held high.
- in_start while busy (any state other than IDLE): ignored, no queuing.
- Reset mid-job: immediate abort, no status write, out_valid drops asynchronously.
- Addresses 0 and 1 (config/status cells) are readable like any other cell.

Optional Feature:
FETCH_CYCLE_COUNT_EN:
- Defined: a 16-bit counter clears on start acceptance and increments every cycle spent in REQ, WAIT, or HOLD. It saturates at 0xFFFF and is reported in out_status bits[31:16] during DONE.
- Undefined: bits[31:16]=0 and no counter logic is present.

Test Plan:
1. Reset: assert in_reset mid-cycle → all outputs 0 immediately; after release busy=0, read_en=0.
2. Basic fetch: base=8, count=2, ready=1 → read_en pulses with address 8 then 12. out_data equals cells 8..11 then 12..15. One status_we with status 0x00000201 (without macro), or 0x00060201 (with macro). busy then drops.
3. Backpressure: base=0, count=1, ready=0 for 5 cycles in HOLD → out_data/out_valid stable, no further read_en. Ready=1 → DONE, status 0x00000101.
4. Empty job: count=0 → DONE next cycle, status 0x00000001, read_en never asserted.
5. Range error:
   - base=1020, count=2 → block at 1020 delivered, second REQ aborts, status 0x00000103.
   - base=1022, count=1 → status 0x00000003, no read.
6. Robustness: in_start pulsed during HOLD is ignored (delivered count unchanged). Reset during WAIT → no status_we. A new job after reset runs normally.
